// File: rtl/light_conflict_monitor.sv
// Traffic-light conflict monitor: latches the first safety violation, counts violating cycles, drives flash.
// Optional LCM_FLASH_TOGGLE_EN: flash toggles every FLASH_HALF cycles while faulted (else flash = fault).
package light_package;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } color_t;
endpackage

module light_conflict_monitor
    import light_package::*;
#(
    parameter int YEL_MIN    = 2,
    parameter int CLR_MIN    = 1,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] e_str_light,
    input  logic [1:0] w_str_light,
    input  logic [1:0] e_left_light,
    input  logic [1:0] w_left_light,
    input  logic [1:0] ns_light,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_cnt,
    output logic       flash
);

    localparam int YW = (YEL_MIN < 1) ? 1 : $clog2(YEL_MIN + 1);
    localparam int CW = (CLR_MIN < 1) ? 1 : $clog2(CLR_MIN + 1);
    localparam logic [YW-1:0] YEL_SAT = YW'(YEL_MIN);
    localparam logic [CW-1:0] CLR_SAT = CW'(CLR_MIN);

    // Light index order: 0 e_str, 1 w_str, 2 e_left, 3 w_left, 4 ns
    logic [1:0]    cur  [5];
    logic [1:0]    prev [5];
    logic [YW-1:0] run  [5];
    logic [CW-1:0] allred_cnt;

    logic [4:0] active;
    logic       all_red;
    logic       legal_set;
    logic       v_conf, v_g2r, v_yshort, v_seq, v_noclr, v_inv;
    logic [2:0] viol;
    logic       latch;
    logic       fault_next;

    assign cur[0] = e_str_light;
    assign cur[1] = w_str_light;
    assign cur[2] = e_left_light;
    assign cur[3] = w_left_light;
    assign cur[4] = ns_light;

    always_comb begin
        active   = '0;
        all_red  = 1'b1;
        v_g2r    = 1'b0;
        v_yshort = 1'b0;
        v_seq    = 1'b0;
        v_noclr  = 1'b0;
        v_inv    = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (cur[i] == YELLOW || cur[i] == GREEN) active[i] = 1'b1;
            if (cur[i] != RED) all_red = 1'b0;
            if (cur[i] == 2'd3) begin
                v_inv = 1'b1;
            end else if (prev[i] != 2'd3) begin
                // Transition checks only apply between two valid colours
                if (prev[i] == GREEN && cur[i] == RED) v_g2r = 1'b1;
                if (prev[i] == YELLOW && cur[i] == RED && run[i] < YEL_SAT) v_yshort = 1'b1;
                if ((prev[i] == RED && cur[i] == YELLOW) ||
                    (prev[i] == YELLOW && cur[i] == GREEN)) v_seq = 1'b1;
                if (prev[i] == RED && cur[i] == GREEN && allred_cnt < CLR_SAT) v_noclr = 1'b1;
            end
        end
        legal_set = ((active & ~5'b00011) == 5'b0) ||
                    ((active & ~5'b00101) == 5'b0) ||
                    ((active & ~5'b01010) == 5'b0) ||
                    ((active & ~5'b01100) == 5'b0) ||
                    ((active & ~5'b10000) == 5'b0);
        v_conf = !legal_set;
    end

    always_comb begin
        viol = 3'd0;
        if      (v_conf)   viol = 3'd1;
        else if (v_g2r)    viol = 3'd2;
        else if (v_yshort) viol = 3'd3;
        else if (v_seq)    viol = 3'd4;
        else if (v_noclr)  viol = 3'd5;
        else if (v_inv)    viol = 3'd6;
    end

    always_comb begin
        latch      = (viol != 3'd0) && (!fault || clear_fault);
        fault_next = latch || (fault && !clear_fault);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 5; i++) begin
                prev[i] <= RED;
                run[i]  <= '0;
            end
            allred_cnt <= CLR_SAT;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                prev[i] <= cur[i];
                if (cur[i] == YELLOW)
                    run[i] <= (run[i] == YEL_SAT) ? run[i] : run[i] + 1'b1;
                else
                    run[i] <= '0;
            end
            if (all_red)
                allred_cnt <= (allred_cnt == CLR_SAT) ? allred_cnt : allred_cnt + 1'b1;
            else
                allred_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault      <= 1'b0;
            fault_code <= '0;
            fault_cnt  <= '0;
        end else begin
            fault <= fault_next;
            if (latch)
                fault_code <= viol;
            else if (!fault_next)
                fault_code <= '0;
            if (viol != 3'd0 && fault_cnt != '1)
                fault_cnt <= fault_cnt + 1'b1;
        end
    end

`ifdef LCM_FLASH_TOGGLE_EN
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FH_LAST = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt;
    logic          flash_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_q   <= 1'b0;
            flash_cnt <= '0;
        end else if (latch) begin
            flash_q   <= 1'b1;
            flash_cnt <= '0;
        end else if (fault_next) begin
            if (flash_cnt == FH_LAST) begin
                flash_cnt <= '0;
                flash_q   <= ~flash_q;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end else begin
            flash_q   <= 1'b0;
            flash_cnt <= '0;
        end
    end

    assign flash = flash_q;
`else
    assign flash = fault;
`endif

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Randomised and directed bench for light_conflict_monitor against a rule-level reference model.
module tb_light_conflict_monitor;

    localparam int YEL_MIN    = 2;
    localparam int CLR_MIN    = 1;
    localparam int FLASH_HALF = 4;
    localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, X = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] e_str_light = R, w_str_light = R, e_left_light = R, w_left_light = R, ns_light = R;
    logic       clear_fault = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;
    logic       flash;

    int checks = 0;
    int failures = 0;

    // Reference model state (unsaturated run lengths; comparisons against minima are equivalent)
    int m_prev [5];
    int m_yrun [5];
    int m_allred;
    bit m_fault;
    int m_code;
    int m_cnt;
    int m_since;

    always #5 clk = ~clk;

    light_conflict_monitor #(
        .YEL_MIN   (YEL_MIN),
        .CLR_MIN   (CLR_MIN),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .e_str_light (e_str_light),
        .w_str_light (w_str_light),
        .e_left_light(e_left_light),
        .w_left_light(w_left_light),
        .ns_light    (ns_light),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_cnt   (fault_cnt),
        .flash       (flash)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Legal groups: {e_str,w_str} {e_left,e_str} {w_left,w_str} {w_left,e_left} {ns}
    function automatic bit in_group(int s, int i);
        case (s)
            0: return (i == 0) || (i == 1);
            1: return (i == 2) || (i == 0);
            2: return (i == 3) || (i == 1);
            3: return (i == 3) || (i == 2);
            default: return (i == 4);
        endcase
    endfunction

    function automatic int worst(int v, int code);
        return (v == 0 || code < v) ? code : v;
    endfunction

    function automatic int model_viol(input int c[5]);
        int v = 0;
        bit any_legal = 0;
        for (int s = 0; s < 5; s++) begin
            bit ok = 1;
            for (int i = 0; i < 5; i++)
                if ((c[i] == 1 || c[i] == 2) && !in_group(s, i)) ok = 0;
            if (ok) any_legal = 1;
        end
        if (!any_legal) v = worst(v, 1);
        for (int i = 0; i < 5; i++) begin
            if (c[i] == 3) v = worst(v, 6);
            else if (m_prev[i] != 3) begin
                if (m_prev[i] == 2 && c[i] == 0) v = worst(v, 2);
                if (m_prev[i] == 1 && c[i] == 0 && m_yrun[i] < YEL_MIN) v = worst(v, 3);
                if ((m_prev[i] == 0 && c[i] == 1) || (m_prev[i] == 1 && c[i] == 2)) v = worst(v, 4);
                if (m_prev[i] == 0 && c[i] == 2 && m_allred < CLR_MIN) v = worst(v, 5);
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_prev[i] = 0;
            m_yrun[i] = 0;
        end
        m_allred = CLR_MIN;
        m_fault  = 0;
        m_code   = 0;
        m_cnt    = 0;
        m_since  = 0;
    endtask

    task automatic model_step(input int c[5], input bit clr);
        int v;
        bit allr = 1;
        v = model_viol(c);
        if (v != 0 && m_cnt < 255) m_cnt++;
        if (v != 0 && (!m_fault || clr)) begin
            m_fault = 1;
            m_code  = v;
            m_since = 0;
        end else if (clr && v == 0) begin
            m_fault = 0;
            m_code  = 0;
        end else if (m_fault) begin
            m_since++;
        end
        for (int i = 0; i < 5; i++) begin
            m_yrun[i] = (c[i] == 1) ? m_yrun[i] + 1 : 0;
            if (c[i] != 0) allr = 0;
            m_prev[i] = c[i];
        end
        m_allred = allr ? m_allred + 1 : 0;
    endtask

    function automatic bit model_flash();
`ifdef LCM_FLASH_TOGGLE_EN
        return m_fault && (((m_since / FLASH_HALF) % 2) == 0);
`else
        return m_fault;
`endif
    endfunction

    task automatic compare_outputs();
        check("fault", fault, m_fault);
        check("fault_code", fault_code, m_code);
        check("fault_cnt", fault_cnt, m_cnt);
        check("flash", flash, model_flash());
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare 1 time unit later
    task automatic cyc(input logic [1:0] es, ws, el, wl, n, input logic clr);
        int cc[5];
        e_str_light = es; w_str_light = ws; e_left_light = el; w_left_light = wl; ns_light = n;
        clear_fault = clr;
        cc = '{int'(es), int'(ws), int'(el), int'(wl), int'(n)};
        @(posedge clk);
        model_step(cc, clr);
        #1;
        compare_outputs();
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_cnt", fault_cnt, 0);
        check("rst_flash", flash, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        logic [15:0] pat_exp;
        logic [1:0]  cur_c [5];
        logic [1:0]  nxt;

        #2;
        reset_pulse();

        // Controller-legal sequence
        cyc(R, R, R, R, R, 0);
        repeat (5) cyc(G, G, R, R, R, 0);
        repeat (2) cyc(Y, Y, R, R, R, 0);
        cyc(R, R, R, R, R, 0);
        repeat (3) cyc(R, R, R, R, G, 0);
        repeat (2) cyc(R, R, R, R, Y, 0);
        cyc(R, R, R, R, R, 0);
        check("legal_fault", fault, 0);
        check("legal_cnt", fault_cnt, 0);

        // ns and e_str green together
        reset_pulse();
        cyc(R, R, R, R, R, 0);
        cyc(G, R, R, R, G, 0);
        check("conf_fault", fault, 1);
        check("conf_code", fault_code, 1);
        check("conf_cnt", fault_cnt, 1);

        // Short yellow, then clean clear, then missing clearance
        reset_pulse();
        cyc(R, R, R, R, R, 0);
        cyc(R, R, G, R, R, 0);
        cyc(R, R, Y, R, R, 0);
        cyc(R, R, R, R, R, 0);
        check("short_y_code", fault_code, 3);
        cyc(R, R, R, R, R, 1);
        check("clear_fault", fault, 0);
        check("clear_code", fault_code, 0);
        check("clear_cnt", fault_cnt, 1);
        repeat (2) cyc(G, R, R, R, R, 0);
        repeat (2) cyc(Y, R, R, R, R, 0);
        cyc(R, R, R, G, R, 0);
        check("noclr_code", fault_code, 5);

        // Conflict together with green->red: conflict wins
        reset_pulse();
        cyc(R, R, R, R, R, 0);
        cyc(G, R, R, R, R, 0);
        cyc(R, R, G, R, G, 0);
        check("prio_code", fault_code, 1);

        // Green->red, then clear concurrent with conflict, then saturation
        reset_pulse();
        cyc(R, R, R, R, R, 0);
        cyc(G, R, R, R, R, 0);
        cyc(R, R, R, R, R, 0);
        check("g2r_code", fault_code, 2);
        cyc(R, R, G, R, G, 1);
        check("relatch_fault", fault, 1);
        check("relatch_code", fault_code, 1);
        repeat (300) cyc(X, X, X, X, X, 0);
        check("sat_cnt", fault_cnt, 255);
        check("sat_code", fault_code, 1);

        // Flash pattern from the latch cycle onward
        reset_pulse();
        cyc(R, R, R, R, R, 0);
        cyc(G, R, R, R, R, 0);
        cyc(R, R, R, R, R, 0);
        pat[15] = flash;
        for (int k = 14; k >= 0; k--) begin
            cyc(R, R, R, R, R, 0);
            pat[k] = flash;
        end
`ifdef LCM_FLASH_TOGGLE_EN
        pat_exp = 16'b1111000011110000;
`else
        pat_exp = 16'hFFFF;
`endif
        check("flash_pattern", pat, pat_exp);
        cyc(R, R, R, R, R, 0);
        check("flash_before_rst", flash, 1);
        reset_pulse();

        // Randomised phase: mostly held colours with occasional legal steps, jumps and invalid codes
        for (int i = 0; i < 5; i++) cur_c[i] = R;
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 399) begin
                reset_pulse();
            end
            for (int i = 0; i < 5; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 85) nxt = cur_c[i];
                else if (r < 93) nxt = (cur_c[i] == R) ? G : (cur_c[i] == G) ? Y : R;
                else if (r < 98) nxt = 2'($urandom_range(0, 2));
                else nxt = X;
                cur_c[i] = nxt;
            end
            cyc(cur_c[0], cur_c[1], cur_c[2], cur_c[3], cur_c[4], $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameter YEL_MIN, default 2: minimum consecutive yellow cycles required before red.
REQ-002 Parameter CLR_MIN, default 1: minimum consecutive all-red cycles required before any red->green.
REQ-003 Parameter FLASH_HALF, default 4: half-period of flash output, in cycles.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 e_str_light, w_str_light, e_left_light, w_left_light, ns_light  in  2 each  colors (light_package: red, yellow, green); the lights being monitored.
REQ-007 clear_fault  in  1  synchronous request to release the latched fault.
REQ-008 fault  out  1  latched violation flag.
REQ-009 fault_code  out  3  code of first violation latched (0 = none).
REQ-010 fault_cnt  out  8  saturating count of cycles with any violation.
REQ-011 flash  out  1  flash-mode drive to downstream signal heads.

Function
REQ-012 Light is "active" when yellow or green; legal active sets are subsets of {e_str,w_str}, {e_left,e_str}, {w_left,w_str}, {w_left,e_left} or {ns}.
REQ-013 Per-light registered history: previous color and yellow-run counter (saturates at YEL_MIN).
REQ-014 Global all-red counter: counts consecutive cycles with all five lights red, saturating at CLR_MIN; cleared in any cycle with an active light.
REQ-015 Violation codes, checked every cycle on current inputs against history:
  1 = conflict (active set not legal);
  2 = green->red directly;
  3 = yellow->red with yellow-run < YEL_MIN;
  4 = illegal sequence (red->yellow or yellow->green);
  5 = red->green with all-red counter < CLR_MIN;
  6 = invalid color encoding on any input.
REQ-016 Simultaneous violations: lowest code wins (1 highest priority).
REQ-017 Legal transitions: red->green (with clearance), green->yellow, yellow->red (after YEL_MIN), and any color held unchanged.
REQ-018 Latency: violation sampled at edge N sets fault=1 and fault_code at edge N (visible the cycle after the offending input).
REQ-019 While fault=1, fault_code holds the first latched code; later violations do not overwrite it.
REQ-020 clear_fault=1 with no violation in that cycle: fault=0 and fault_code=0 at the next edge.
REQ-021 clear_fault=1 with a violation in the same cycle: fault stays 1 and fault_code takes the new violation's code.
REQ-022 fault_cnt increments by 1 in each cycle with any violation, holds at 255, and is not affected by clear_fault.
REQ-023 History registers update every cycle regardless of fault state.
REQ-024 flash is 0 while fault=0.

Reset
REQ-025 Asynchronous assertion of reset_n=0: fault=0, fault_code=0, fault_cnt=0, flash=0, flash counter 0.
REQ-026 Reset history values: all previous colors red, yellow-runs 0, all-red counter = CLR_MIN, so the first green after reset is legal.
REQ-027 Reset mid-fault discards the latched fault and all history immediately.
REQ-028 Reset deasserts synchronously to clk, and checking starts on the first edge after deassertion.

Configuration
REQ-029 Macro LCM_FLASH_TOGGLE_EN.
  Defined: while fault=1, flash toggles every FLASH_HALF cycles, starting at 1 on the cycle fault rises; the counter restarts on each new latch.
  Undefined: flash = fault (steady); no flash counter is present.

Verification
REQ-030 Controller-legal sequence (all red 1 cycle, e_str/w_str green 5, yellow 2, all red 1, ns green 3) -> fault=0, fault_cnt=0 throughout.
REQ-031 ns=green and e_str=green in the same cycle -> fault=1, fault_code=1 next cycle; fault_cnt=1.
REQ-032 e_left green->yellow 1 cycle->red -> fault_code=3. Then clear_fault=1 on a clean cycle -> fault=0, fault_code=0; fault_cnt stays 1.
REQ-033 Yellow ends on cycle N and w_left goes green on N+1 with no all-red cycle -> fault_code=5. Conflict plus green->red in the same cycle -> fault_code=1.
REQ-034 Latched fault code 2, then clear_fault concurrent with a new conflict -> fault stays 1, fault_code=1. Force 300 violation cycles -> fault_cnt=255.
REQ-035 Fault latched with LCM_FLASH_TOGGLE_EN, FLASH_HALF=4 -> flash pattern 1111000011110000. Without the macro -> flash=1 steady. reset_n=0 mid-flash -> all outputs 0 immediately.
